// File: rtl/gf251_sample_32.sv
// gf251_sample_32
//   Rejection sampler for GF(251). It draws random bytes from a 32-bit input
//   stream, keeps only bytes 0x00..0xFA (values below 251) and packs every
//   four accepted bytes, oldest first, into one 32-bit output word of four
//   GF(251) lanes. A run produces exactly the requested number of words and
//   then ends with a one-cycle o_done pulse.
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        synchronous, active-high reset
//   i_start      start a run (honoured in IDLE only)
//   i_count      number of output words in the run, latched on start
//   i_rnd        four random bytes, byte 0 = bits[7:0] handled first
//   i_rnd_valid  i_rnd is valid
//   o_rnd_ready  block takes i_rnd this cycle
//   o_o          four packed GF(251) elements, lane 0 = bits[7:0]
//   o_valid      o_o holds a valid word
//   i_ready      downstream takes o_o
//   o_done       one-cycle pulse at the end of a run
//   o_busy       high in every state except IDLE
//   o_rej_cnt    (GF251_SAMPLE_STATS_EN only) saturating count of rejected
//                bytes, cleared by reset and by an accepted start
//
// Optional feature macro: GF251_SAMPLE_STATS_EN
//
// State    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for i_start; buffer empty, no output word
// S_RUN    | sampling; collecting bytes and emitting words
// S_DONE   | run finished; o_done high for this one cycle
module gf251_sample_32 #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [31:0]      i_rnd,
  input  logic             i_rnd_valid,
  output logic             o_rnd_ready,
  output logic [31:0]      o_o,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done,
  output logic             o_busy
`ifdef GF251_SAMPLE_STATS_EN
  ,
  output logic [15:0]      o_rej_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // Byte buffer: entry 0 is the oldest byte. Seven entries suffice because
  // input is only taken at occupancy <= 3 and one word adds at most 4 bytes.
  logic [7:0]       buf_q [7];
  logic [7:0]       buf_d [7];
  logic [2:0]       occ_q, occ_d;
  logic [2:0]       wr_idx;

  logic [7:0]       acc_bytes [4];
  logic [2:0]       acc_cnt;

  logic             start_acc;
  logic             in_xfer;
  logic             out_hs;
  logic             last_hs;
  logic             load;

  // Compact the accepted bytes of the incoming word, preserving order.
  // acc_cnt never exceeds the loop index here, so its low two bits index
  // acc_bytes safely.
  always_comb begin
    acc_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      acc_bytes[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      if (i_rnd[8*i +: 8] <= 8'hFA) begin
        acc_bytes[acc_cnt[1:0]] = i_rnd[8*i +: 8];
        acc_cnt = acc_cnt + 3'd1;
      end
    end
  end

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign in_xfer   = i_rnd_valid && o_rnd_ready;
  assign out_hs    = o_valid && i_ready;
  assign last_hs   = out_hs && (state_q == S_RUN) && (rem_q == CNT_W'(1));
  // The last handshake blocks any further load; leftover bytes are dropped.
  assign load      = (state_q == S_RUN) && (occ_q >= 3'd4) &&
                     (!o_valid || i_ready) && !last_hs;

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_rnd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          rem_d   = i_count;
          state_d = (i_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        o_rnd_ready = (occ_q <= 3'd3);
        if (out_hs) begin
          rem_d = rem_q - CNT_W'(1);
        end
        if (last_hs) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer update: first retire the 4 oldest bytes on a load, then append
  // the accepted bytes of an input transfer behind whatever remains.
  // A transfer requires occupancy <= 3, so wr_idx stays within 0..6.
  always_comb begin
    buf_d  = buf_q;
    occ_d  = occ_q;
    wr_idx = occ_q;
    if (load) begin
      buf_d[0] = buf_q[4];
      buf_d[1] = buf_q[5];
      buf_d[2] = buf_q[6];
      buf_d[3] = 8'h00;
      buf_d[4] = 8'h00;
      buf_d[5] = 8'h00;
      buf_d[6] = 8'h00;
      occ_d    = occ_q - 3'd4;
    end
    if (in_xfer) begin
      for (int j = 0; j < 4; j++) begin
        wr_idx = occ_d + 3'(j);
        if (3'(j) < acc_cnt) begin
          buf_d[wr_idx] = acc_bytes[j];
        end
      end
      occ_d = occ_d + acc_cnt;
    end
    if (last_hs || start_acc) begin
      occ_d = 3'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      occ_q   <= 3'd0;
      o_o     <= 32'h0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
      if (load) begin
        o_o     <= {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
        o_valid <= 1'b1;
      end else if (out_hs) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Buffer contents are qualified by occ_q, so the data needs no reset.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

`ifdef GF251_SAMPLE_STATS_EN
  logic [16:0] rej_sum;

  always_comb begin
    rej_sum = {1'b0, o_rej_cnt} + 17'(3'd4 - acc_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || start_acc) begin
      o_rej_cnt <= 16'h0;
    end else if (in_xfer) begin
      o_rej_cnt <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_gf251_sample_32.sv
// Self-checking bench for gf251_sample_32. A monitor turns every observed
// input transfer into a stream of accepted bytes and packs the expected
// words into a scoreboard queue; every output handshake pops and compares.
module tb_gf251_sample_32;
  localparam int CNT_W = 10;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start;
  logic [CNT_W-1:0] i_count;
  logic [31:0]      i_rnd;
  logic             i_rnd_valid;
  logic             o_rnd_ready;
  logic [31:0]      o_o;
  logic             o_valid;
  logic             i_ready;
  logic             o_done;
  logic             o_busy;
`ifdef GF251_SAMPLE_STATS_EN
  logic [15:0]      o_rej_cnt;
`endif

  gf251_sample_32 #(.CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_count     (i_count),
    .i_rnd       (i_rnd),
    .i_rnd_valid (i_rnd_valid),
    .o_rnd_ready (o_rnd_ready),
    .o_o         (o_o),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_done      (o_done),
    .o_busy      (o_busy)
`ifdef GF251_SAMPLE_STATS_EN
    ,
    .o_rej_cnt   (o_rej_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  mbytes [$];
  logic [7:0]  mb;
  int          run_count = 0;
  int          words_made = 0;
  int          hs_run = 0;
  int          done_seen = 0;
  int          rej_model = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_o = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard. Inputs change #1 after posedge, so at negedge
  // they show what the next rising edge will act on.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", o_o, prev_o);
        end
        if (o_done) done_seen++;
        if (i_rnd_valid && o_rnd_ready) begin
          for (int i = 0; i < 4; i++) begin
            mb = i_rnd[8*i +: 8];
            if (mb <= 8'd250) mbytes.push_back(mb);
            else if (rej_model < 65535) rej_model++;
          end
          while (mbytes.size() >= 4 && words_made < run_count) begin
            exp_q.push_back({mbytes[3], mbytes[2], mbytes[1], mbytes[0]});
            repeat (4) void'(mbytes.pop_front());
            words_made++;
          end
        end
        if (o_valid && i_ready) begin
          hs_run++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected no word", o_o);
          end else begin
            chk("word", o_o, exp_q.pop_front());
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_o     = o_o;
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) w[8*i +: 8] = 8'(8'hFB + 8'($urandom_range(0, 4)));
      else                           w[8*i +: 8] = 8'($urandom_range(0, 250));
    end
    return w;
  endfunction

  function automatic logic [31:0] good_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(0, 250));
    return w;
  endfunction

  // One cycle of stimulus; returns at negedge+1 with outputs settled.
  task automatic cyc(input logic st, input logic [CNT_W-1:0] cnt, input logic v,
                     input logic [31:0] d, input logic r);
    @(posedge i_clk); #1;
    i_start = st; i_count = cnt; i_rnd_valid = v; i_rnd = d; i_ready = r;
    @(negedge i_clk); #1;
  endtask

  task automatic start_run(input int cnt);
    mbytes.delete();
    words_made = 0;
    hs_run     = 0;
    rej_model  = 0;
    run_count  = cnt;
    cyc(1'b1, CNT_W'(cnt), 1'b0, 32'h0, 1'b0);
  endtask

  // mode 0: no input, always ready; 1: good words, ready; 2: random.
  task automatic finish_run(input int mode);
    int n = 0;
    while (!o_done && n < 3000) begin
      case (mode)
        0:       cyc(1'b0, '0, 1'b0, 32'h0, 1'b1);
        1:       cyc(1'b0, '0, 1'b1, good_word(), 1'b1);
        default: cyc(1'b0, '0, $urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0);
      endcase
      n++;
    end
    chk("done_reached", 32'(o_done), 32'd1);
    chk("word_count", 32'(hs_run), 32'(run_count));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef GF251_SAMPLE_STATS_EN
    chk("rej_cnt", 32'(o_rej_cnt), 32'(rej_model));
`endif
    exp_q.delete();
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b0);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_after_done", 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_start = 1'b0; i_rnd_valid = 1'b0; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk); #1;
    chk("rst_o", o_o, 32'h0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_rnd_ready), 32'd0);
`ifdef GF251_SAMPLE_STATS_EN
    chk("rst_rej", 32'(o_rej_cnt), 32'd0);
`endif
    mbytes.delete();
    exp_q.delete();
    run_count = 0; words_made = 0; hs_run = 0; rej_model = 0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    chk("post_rst_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    i_start = 1'b0; i_count = '0; i_rnd = 32'h0; i_rnd_valid = 1'b0; i_ready = 1'b0;
    do_reset();

    // Single word, with fixed latency from transfer to o_valid.
    start_run(1);
    cyc(1'b0, '0, 1'b1, 32'h04030201, 1'b1);
    chk("run_ready", 32'(o_rnd_ready), 32'd1);
    chk("lat_pre", 32'(o_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b1);
    chk("lat_k", 32'(o_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b1);
    chk("lat_k1", 32'(o_valid), 32'd1);
    chk("lat_data", o_o, 32'h04030201);
    finish_run(0);

    // Rejected bytes interleaved; byte 0x05 left over and dropped.
    start_run(1);
    cyc(1'b0, '0, 1'b1, 32'hFB020100, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h05FFFC03, 1'b0);
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b0);
    finish_run(0);
`ifdef GF251_SAMPLE_STATS_EN
    chk("rej_three", 32'(o_rej_cnt), 32'd3);
`endif

    // Backpressure: output held, input throttled at occupancy 4.
    start_run(2);
    repeat (5) cyc(1'b0, '0, 1'b1, 32'h0A0A0A0A, 1'b0);
    chk("bp_ready", 32'(o_rnd_ready), 32'd0);
    chk("bp_valid", 32'(o_valid), 32'd1);
    chk("bp_data", o_o, 32'h0A0A0A0A);
    finish_run(0);

    // Zero-length run.
    start_run(0);
    cyc(1'b0, '0, 1'b1, 32'h01010101, 1'b1);
    chk("zero_busy", 32'(o_busy), 32'd1);
    chk("zero_done", 32'(o_done), 32'd1);
    chk("zero_valid", 32'(o_valid), 32'd0);
    chk("zero_ready", 32'(o_rnd_ready), 32'd0);
    finish_run(0);

    // Reset mid-run with 3 bytes buffered, then a clean run.
    start_run(1);
    cyc(1'b0, '0, 1'b1, 32'hFF030201, 1'b0);
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b0);
    d0 = done_seen;
    do_reset();
    chk("abort_no_done", 32'(done_seen), 32'(d0));
    start_run(1);
    cyc(1'b0, '0, 1'b1, 32'hF0F1F2F3, 1'b1);
    finish_run(1);

    // All-rejected words are consumed without effect.
    start_run(1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b1, 32'hFFFFFFFF, 1'b1);
      chk("allrej_ready", 32'(o_rnd_ready), 32'd1);
      chk("allrej_valid", 32'(o_valid), 32'd0);
    end
    cyc(1'b0, '0, 1'b0, 32'h0, 1'b1);
    chk("allrej_valid_end", 32'(o_valid), 32'd0);
`ifdef GF251_SAMPLE_STATS_EN
    chk("rej_forty", 32'(o_rej_cnt), 32'd40);
`endif
    finish_run(1);

    // Start ignored while running.
    start_run(3);
    cyc(1'b1, CNT_W'(1), 1'b1, good_word(), 1'b1);
    finish_run(2);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      start_run($urandom_range(0, 8));
      finish_run(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
